// File: rtl/prog_uart_loader_pkg.sv
// Shared encodings and framing constants for the UART program loader.
// Imported by the loader top, its UART receiver and the program-memory interface users.
package prog_uart_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/prog_uart_loader_if.sv
// Program-memory write port driven by the loader.
// prog_we_o is a one-cycle write strobe; there is no ready, the memory must accept every
// strobe. prog_addr_o/prog_data_o are valid with the strobe and held until the next one.
interface prog_uart_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  prog_we_o;
  logic [ADDR_WIDTH-1:0] prog_addr_o;
  logic [DATA_WIDTH-1:0] prog_data_o;

  modport master (output prog_we_o, output prog_addr_o, output prog_data_o);
  modport slave  (input  prog_we_o, input  prog_addr_o, input  prog_data_o);
endinterface

// File: rtl/prog_uart_loader_uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
// byte_valid_o / frame_err_o are mutually exclusive one-cycle pulses at the stop-bit sample.
module uart_rx_byte
  import prog_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output rx_state_t  state_o
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_t   state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) state_d = RX_START;
      end
      RX_START: begin
        // Half-bit wait puts every later sample in the middle of its bit cell.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s2_q;
          ferr_d  = !rx_s2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = sh_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign state_o      = state_q;

endmodule

// File: rtl/prog_uart_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART, writes it
// sequentially into program memory and holds the core in reset until the image is complete.
module prog_uart_loader
  import prog_uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx_i,
  prog_uart_loader_if.master  prog,
  output logic                core_rst_o,
  output logic                done_o,
  output logic                err_o,
  output loader_state_t       state_o,
  output rx_state_t           rx_state_o
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (uart_rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err),
    .state_o      (rx_state_o)
  );

  loader_state_t         state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-9:0] asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_LEN0: begin
        if (byte_valid) begin
          len_d   = {8'h00, rx_byte};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (byte_valid) begin
          len_d  = {rx_byte, len_q[7:0]};
          widx_d = '0;
          lane_d = '0;
          if ({rx_byte, len_q[7:0]} == 16'h0000)          state_d = S_DONE;
          else if ({1'b0, rx_byte, len_q[7:0]} > MAX_WORDS) state_d = S_ERR;
          else                                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Leave one cycle after the final strobe so done follows the last write.
        if (we_q && (17'(widx_q) == 17'(len_q))) begin
          state_d = S_DONE;
        end else if (byte_valid) begin
          if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
            we_d   = 1'b1;
            addr_d = widx_q[ADDR_WIDTH-1:0];
            data_d = {rx_byte, asm_q};
            widx_d = widx_q + 1'b1;
            lane_d = '0;
          end else begin
            asm_d  = {rx_byte, asm_q[DATA_WIDTH-9:8]};
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (frame_err && state_q != S_DONE) state_d = S_ERR;
  end

  assign prog.prog_we_o   = we_q;
  assign prog.prog_addr_o = addr_q;
  assign prog.prog_data_o = data_q;
  assign core_rst_o       = (state_q != S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = (state_q == S_ERR);
  assign state_o          = state_q;

endmodule
